// File: rtl/lq_entry_dispatch.sv
// Read side of the load-queue FIFO: pops the head into a one-entry issue stage and tags it with an ID.
// Latency: FIFO head to req_valid is one cycle. Backpressure: stalls on req_ready or on the outstanding-load limit.
module lq_entry_dispatch #(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_pop,
    output logic                  req_valid,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [ID_WIDTH-1:0]   req_id,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic                  flush,
    output logic [3:0]            outstanding_count,
    output logic                  busy
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    logic   fire;
    logic   stage_free;
    logic   credit_ok;
    logic   rsp_take;
    logic   issue_load;

    assign fire       = req_valid & req_ready;
    assign stage_free = ~req_valid | req_ready;
    // The staged entry will consume a credit when it fires, so it counts against the limit now.
    assign credit_ok  = ({1'b0, outstanding_count} + {4'd0, req_valid}) < 5'(MAX_OUTSTANDING);
    assign rsp_take   = rsp_valid & (outstanding_count != 4'd0);

    always_comb begin
        fifo_pop = 1'b0;
        if (rst) begin
            if (state == DRAIN)
                fifo_pop = fifo_valid;
            else
                fifo_pop = fifo_valid & ~flush & stage_free & credit_ok;
        end
    end

    assign issue_load = fifo_pop & (state == RUN);
    assign busy       = req_valid | (outstanding_count != 4'd0) | (state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= RUN;
            req_valid         <= 1'b0;
            req_id            <= '0;
            outstanding_count <= 4'd0;
        end else begin
            case (state)
                RUN:   if (flush) state <= DRAIN;
                DRAIN: if (!fifo_valid && !flush) state <= RUN;
                default: state <= RUN;
            endcase

            if (flush)
                req_valid <= 1'b0;
            else if (issue_load)
                req_valid <= 1'b1;
            else if (fire)
                req_valid <= 1'b0;

            // A request that fires under flush was still delivered, so it keeps its tag and credit.
            if (fire)
                req_id <= req_id + ID_WIDTH'(1);

            if (fire && !rsp_take)
                outstanding_count <= outstanding_count + 4'd1;
            else if (!fire && rsp_take)
                outstanding_count <= outstanding_count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_load)
            req_data <= fifo_data_out;
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        fifo_pop |-> fifo_valid);

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
        (req_valid && !req_ready) |=> ($stable(req_data) && $stable(req_id)));

    a_count_limit: assert property (@(posedge clk) disable iff (!rst)
        outstanding_count <= 4'(MAX_OUTSTANDING));

    a_rsp_with_credit: assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> (outstanding_count != 4'd0));

endmodule

// File: tb/tb_lq_entry_dispatch.sv
// Directed bench for lq_entry_dispatch: a queue stands in for the load-queue FIFO.
// Expected values are worked out by hand cycle by cycle.
module tb_lq_entry_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_valid;
    logic [63:0] fifo_data_out;
    logic        fifo_pop;
    logic        req_valid;
    logic [63:0] req_data;
    logic [2:0]  req_id;
    logic        req_ready;
    logic        rsp_valid;
    logic        flush;
    logic [3:0]  outstanding_count;
    logic        busy;

    int          passed = 0;
    int          total  = 0;
    logic [63:0] q[$];
    logic        pop_seen = 1'b0;

    lq_entry_dispatch #(
        .DATA_WIDTH(64),
        .MAX_OUTSTANDING(4),
        .ID_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_valid(fifo_valid),
        .fifo_data_out(fifo_data_out),
        .fifo_pop(fifo_pop),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_id(req_id),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .flush(flush),
        .outstanding_count(outstanding_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs only move just after a rising edge, so the falling-edge value is what the next edge sees.
    always @(negedge clk) pop_seen <= fifo_pop;

    task automatic drive_fifo();
        fifo_valid = (q.size() != 0);
        if (q.size() != 0) fifo_data_out = q[0];
        else               fifo_data_out = 64'd0;
    endtask

    task automatic push(input logic [63:0] d);
        q.push_back(d);
        drive_fifo();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen && q.size() != 0) void'(q.pop_front());
        drive_fifo();
        #1;
    endtask

    task automatic go_idle();
        int guard = 0;
        flush = 1'b0;
        req_ready = 1'b1;
        while ((q.size() != 0 || req_valid || outstanding_count != 4'd0 || busy) && guard < 60) begin
            rsp_valid = (outstanding_count != 4'd0);
            tick();
            guard++;
        end
        rsp_valid = 1'b0;
        #1;
        total++; if (outstanding_count !== 4'd0 || req_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_timeout: count=%0d req_valid=%b busy=%b expected 0/0/0", outstanding_count, req_valid, busy); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
        q.delete();
        push(64'hE0);
        tick();
        tick();
        total++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", req_valid); else passed++;
        total++; if (req_id !== 3'd0) $display("FAIL reset_req_id: got %0d expected 0", req_id); else passed++;
        total++; if (outstanding_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", outstanding_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (fifo_pop !== 1'b0) $display("FAIL reset_pop: got %b expected 0", fifo_pop); else passed++;
        q.delete();
        drive_fifo();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        req_ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0;
        push(64'hA1); push(64'hA2); push(64'hA3);
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL stream_pop0: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_valid !== 1'b1 || req_data !== 64'hA1 || req_id !== 3'd0) $display("FAIL stream_a1: valid=%b data=%h id=%0d expected 1/a1/0", req_valid, req_data, req_id); else passed++;
        total++; if (fifo_pop !== 1'b1) $display("FAIL stream_pop1: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_data !== 64'hA2 || req_id !== 3'd1 || outstanding_count !== 4'd1) $display("FAIL stream_a2: data=%h id=%0d count=%0d expected a2/1/1", req_data, req_id, outstanding_count); else passed++;
        total++; if (fifo_pop !== 1'b1) $display("FAIL stream_pop2: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_data !== 64'hA3 || req_id !== 3'd2 || outstanding_count !== 4'd2) $display("FAIL stream_a3: data=%h id=%0d count=%0d expected a3/2/2", req_data, req_id, outstanding_count); else passed++;
        total++; if (fifo_pop !== 1'b0) $display("FAIL stream_pop3: got %b expected 0", fifo_pop); else passed++;
        rsp_valid = 1'b1;
        tick();
        total++; if (outstanding_count !== 4'd2 || req_valid !== 1'b0) $display("FAIL fire_rsp_same_cycle: count=%0d valid=%b expected 2/0", outstanding_count, req_valid); else passed++;
        tick();
        total++; if (outstanding_count !== 4'd1 || busy !== 1'b1) $display("FAIL stream_count1: count=%0d busy=%b expected 1/1", outstanding_count, busy); else passed++;
        tick();
        rsp_valid = 1'b0;
        #1;
        total++; if (outstanding_count !== 4'd0 || busy !== 1'b0) $display("FAIL stream_done: count=%0d busy=%b expected 0/0", outstanding_count, busy); else passed++;
    endtask

    task automatic test_credit_limit();
        req_ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 6; i++) push(64'hC0 + 64'(i));
        #1;
        tick(); tick(); tick(); tick();
        total++; if (outstanding_count !== 4'd3 || req_data !== 64'hC3 || fifo_pop !== 1'b0) $display("FAIL credit_fourth: count=%0d data=%h pop=%b expected 3/c3/0", outstanding_count, req_data, fifo_pop); else passed++;
        tick();
        total++; if (outstanding_count !== 4'd4 || req_valid !== 1'b0 || fifo_pop !== 1'b0) $display("FAIL credit_full: count=%0d valid=%b pop=%b expected 4/0/0", outstanding_count, req_valid, fifo_pop); else passed++;
        tick();
        rsp_valid = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b0) $display("FAIL credit_rsp_same_cycle: pop=%b expected 0", fifo_pop); else passed++;
        tick();
        rsp_valid = 1'b0;
        #1;
        total++; if (outstanding_count !== 4'd3 || fifo_pop !== 1'b1) $display("FAIL credit_fifth_pop: count=%0d pop=%b expected 3/1", outstanding_count, fifo_pop); else passed++;
        go_idle();
        total++; if (req_id !== 3'd1) $display("FAIL credit_id_after: got %0d expected 1", req_id); else passed++;
    endtask

    task automatic test_stall();
        req_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
        push(64'hB7); push(64'hB8); push(64'hB9);
        #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (req_valid !== 1'b1 || req_data !== 64'hB7 || req_id !== 3'd1 || fifo_pop !== 1'b0) $display("FAIL stall_hold_%0d: valid=%b data=%h id=%0d pop=%b expected 1/b7/1/0", i, req_valid, req_data, req_id, fifo_pop); else passed++;
            if (i < 4) tick();
        end
        req_ready = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL stall_release_pop: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_valid !== 1'b1 || req_data !== 64'hB8 || req_id !== 3'd2 || outstanding_count !== 4'd1) $display("FAIL stall_next: valid=%b data=%h id=%0d count=%0d expected 1/b8/2/1", req_valid, req_data, req_id, outstanding_count); else passed++;
        go_idle();
        total++; if (req_id !== 3'd4) $display("FAIL stall_id_after: got %0d expected 4", req_id); else passed++;
    endtask

    task automatic test_flush_drain();
        req_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
        push(64'hF0); push(64'hF1); push(64'hF2); push(64'hF3);
        #1;
        tick();
        flush = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b0 || req_data !== 64'hF0) $display("FAIL flush_cycle: pop=%b data=%h expected 0/f0", fifo_pop, req_data); else passed++;
        tick();
        flush = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (req_valid !== 1'b0 || fifo_pop !== 1'b1 || busy !== 1'b1) $display("FAIL drain_pop_%0d: valid=%b pop=%b busy=%b expected 0/1/1", i, req_valid, fifo_pop, busy); else passed++;
            tick();
        end
        total++; if (req_valid !== 1'b0 || fifo_pop !== 1'b0 || busy !== 1'b1) $display("FAIL drain_empty: valid=%b pop=%b busy=%b expected 0/0/1", req_valid, fifo_pop, busy); else passed++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL drain_exit: busy=%b expected 0", busy); else passed++;
        req_ready = 1'b1;
        push(64'hF9);
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL flush_resume_pop: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_valid !== 1'b1 || req_data !== 64'hF9 || req_id !== 3'd4) $display("FAIL flush_resume: valid=%b data=%h id=%0d expected 1/f9/4", req_valid, req_data, req_id); else passed++;
        go_idle();
    endtask

    task automatic test_flush_fire();
        req_ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0;
        push(64'h6000_0000_0000_0061); push(64'h6000_0000_0000_0062);
        #1;
        tick();
        flush = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b0 || req_id !== 3'd5) $display("FAIL flush_fire_pop: pop=%b id=%0d expected 0/5", fifo_pop, req_id); else passed++;
        tick();
        flush = 1'b0;
        #1;
        total++; if (req_valid !== 1'b0 || outstanding_count !== 4'd1 || req_id !== 3'd6) $display("FAIL flush_fire_counts: valid=%b count=%0d id=%0d expected 0/1/6", req_valid, outstanding_count, req_id); else passed++;
        total++; if (fifo_pop !== 1'b1) $display("FAIL flush_fire_drain_pop: got %b expected 1", fifo_pop); else passed++;
        tick();
        total++; if (req_valid !== 1'b0) $display("FAIL flush_fire_discard: valid=%b expected 0", req_valid); else passed++;
        go_idle();
        total++; if (req_id !== 3'd6) $display("FAIL flush_fire_id_after: got %0d expected 6", req_id); else passed++;
    endtask

    task automatic test_reset_mid();
        req_ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 5; i++) push(64'hD0 + 64'(i));
        #1;
        tick(); tick(); tick(); tick();
        total++; if (req_valid !== 1'b1 || outstanding_count !== 4'd3) $display("FAIL rstmid_pre: valid=%b count=%0d expected 1/3", req_valid, outstanding_count); else passed++;
        rst = 1'b0;
        #1;
        total++; if (fifo_pop !== 1'b0) $display("FAIL rstmid_pop_low: got %b expected 0", fifo_pop); else passed++;
        tick();
        total++; if (req_valid !== 1'b0 || outstanding_count !== 4'd0 || busy !== 1'b0 || req_id !== 3'd0 || fifo_pop !== 1'b0) $display("FAIL rstmid_after: valid=%b count=%0d busy=%b id=%0d pop=%b expected 0/0/0/0/0", req_valid, outstanding_count, busy, req_id, fifo_pop); else passed++;
        rst = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b1 || fifo_data_out !== 64'hD4) $display("FAIL rstmid_fifo_kept: pop=%b head=%h expected 1/d4", fifo_pop, fifo_data_out); else passed++;
        go_idle();
    endtask

    task automatic test_id_wrap();
        int n = 0;
        int guard = 0;
        logic [2:0] exp_id;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_ready = 1'b1; rsp_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 9; i++) push(64'h100 + 64'(i));
        while (n < 9 && guard < 40) begin
            rsp_valid = (outstanding_count != 4'd0);
            #1;
            if (req_valid && req_ready) begin
                exp_id = 3'(n);
                total++; if (req_id !== exp_id || req_data !== 64'h100 + 64'(n)) $display("FAIL id_wrap_%0d: id=%0d data=%h expected %0d/%h", n, req_id, req_data, exp_id, 64'h100 + 64'(n)); else passed++;
                n++;
            end
            tick();
            guard++;
        end
        total++; if (n !== 9) $display("FAIL id_wrap_fires: got %0d expected 9", n); else passed++;
        go_idle();
    endtask

    initial begin
        rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
        fifo_valid = 1'b0; fifo_data_out = 64'd0;
        test_reset();
        test_streaming();
        test_credit_limit();
        test_stall();
        test_flush_drain();
        test_flush_fire();
        test_reset_mid();
        test_id_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
